// File: rtl/rv32i_types.sv
// Shared LSU types: op encodings, LSU state enum and the queue entry layout.
// Entry field widths follow the package localparams; the LSU's TAG_W/ROB_PTR_W must not exceed them.
package rv32i_types;

  localparam int LSQ_TAG_W     = 4;
  localparam int LSQ_ROB_PTR_W = 4;

  // bit3 = store, bit2 = unsigned load, bits[1:0] = log2(access size)
  localparam logic [3:0] lsu_op_lb  = 4'b0000;
  localparam logic [3:0] lsu_op_lh  = 4'b0001;
  localparam logic [3:0] lsu_op_lw  = 4'b0010;
  localparam logic [3:0] lsu_op_lbu = 4'b0100;
  localparam logic [3:0] lsu_op_lhu = 4'b0101;
  localparam logic [3:0] lsu_op_sb  = 4'b1000;
  localparam logic [3:0] lsu_op_sh  = 4'b1001;
  localparam logic [3:0] lsu_op_sw  = 4'b1010;

  typedef enum logic [1:0] {IDLE, MEM, RESP, DRAIN} lsu_state_t;

  typedef struct packed {
    logic                     valid;
    logic [3:0]               opc;
    logic [LSQ_TAG_W-1:0]     tag;
    logic [31:0]              addr;
    logic [31:0]              wdata;
    logic [LSQ_ROB_PTR_W-1:0] inst_id;
  } lsq_entry_t;

  function automatic logic lsu_misaligned(input logic [1:0] size_code, input logic [1:0] off);
    case (size_code)
      2'b01:   return off[0];
      2'b10:   return off != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Selects and extends the loaded byte/half/word from a 32-bit memory word.
module lsu_load_align
  import rv32i_types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [3:0]  opc,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{off, 3'b000} +: 8];
    half_sel = off[1] ? rdata[31:16] : rdata[15:0];
    case (opc)
      lsu_op_lb:  result = {{24{byte_sel[7]}}, byte_sel};
      lsu_op_lbu: result = {24'b0, byte_sel};
      lsu_op_lh:  result = {{16{half_sel[15]}}, half_sel};
      lsu_op_lhu: result = {16'b0, half_sel};
      // stores complete with zero data
      default:    result = opc[3] ? 32'b0 : rdata;
    endcase
  end

endmodule

// File: rtl/lsu_lsq_v2.sv
// Program-ordered load/store queue issuing one data-memory access at a time from its head,
// with flush recovery, misalignment exceptions and a held, registered CDB result.
module lsu_lsq_v2
  import rv32i_types::*;
#(
  parameter int TAG_W     = 4,
  parameter int ROB_DEPTH = 16,
  parameter int ROB_PTR_W = $clog2(ROB_DEPTH),
  parameter int DEPTH     = 8,
  parameter int PTR_W     = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 iss_req,
  output logic                 iss_rdy,
  input  logic [3:0]           iss_opc,
  input  logic [TAG_W-1:0]     iss_tag,
  input  logic [31:0]          iss_src1,
  input  logic [31:0]          iss_src2,
  input  logic [11:0]          iss_offset,
  input  logic [ROB_PTR_W-1:0] iss_inst_id,
  input  logic                 rob_head_vld,
  input  logic [ROB_PTR_W-1:0] rob_head_id,
  output logic                 cdb_req,
  input  logic                 cdb_rdy,
  output logic [TAG_W-1:0]     cdb_tag,
  output logic [ROB_PTR_W-1:0] cdb_inst_id,
  output logic [31:0]          cdb_wdata,
  output logic                 cdb_exc,
  output logic [31:0]          dmem_addr,
  output logic [3:0]           dmem_rmask,
  output logic [3:0]           dmem_wmask,
  output logic [31:0]          dmem_wdata,
  input  logic [31:0]          dmem_rdata,
  input  logic                 dmem_resp
);

  lsq_entry_t                lsq_mem [DEPTH];
  logic       [PTR_W:0]      wptr_reg, rptr_reg;
  lsu_state_t                state_reg, state_next;
  logic       [3:0]          opc_reg;
  logic       [1:0]          off_reg;
  logic       [TAG_W-1:0]    cdb_tag_reg;
  logic       [ROB_PTR_W-1:0] cdb_inst_id_reg;
  logic       [31:0]         cdb_wdata_reg;
  logic                      cdb_exc_reg;

  lsq_entry_t  head;
  logic        full, empty, enq, deq, head_mis, issue;
  logic [31:0] load_result;

  assign full  = (wptr_reg[PTR_W-1:0] == rptr_reg[PTR_W-1:0]) && (wptr_reg[PTR_W] != rptr_reg[PTR_W]);
  assign empty = (wptr_reg == rptr_reg);
  assign head  = lsq_mem[rptr_reg[PTR_W-1:0]];

  assign iss_rdy  = ~full;
  assign enq      = iss_req && !full && !flush;
  assign head_mis = lsu_misaligned(head.opc[1:0], head.addr[1:0]);
  // Stores may only touch memory once they are the oldest uncommitted instruction.
  assign deq      = (state_reg == IDLE) && !empty && head.valid && !flush &&
                    (!head.opc[3] || (rob_head_vld && rob_head_id == ROB_PTR_W'(head.inst_id)));
  assign issue    = deq && !head_mis;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      for (int i = 0; i < DEPTH; i++) lsq_mem[i].valid <= 1'b0;
    end else begin
      if (enq) begin
        lsq_mem[wptr_reg[PTR_W-1:0]] <= '{valid:   1'b1,
                                          opc:     iss_opc,
                                          tag:     LSQ_TAG_W'(iss_tag),
                                          addr:    iss_src1 + {{20{iss_offset[11]}}, iss_offset},
                                          wdata:   iss_src2,
                                          inst_id: LSQ_ROB_PTR_W'(iss_inst_id)};
        wptr_reg <= wptr_reg + 1'b1;
      end
      if (deq) begin
        lsq_mem[rptr_reg[PTR_W-1:0]].valid <= 1'b0;
        rptr_reg <= rptr_reg + 1'b1;
      end
    end
  end

  always_comb begin
    dmem_addr  = '0;
    dmem_rmask = '0;
    dmem_wmask = '0;
    dmem_wdata = '0;
    if (issue) begin
      dmem_addr = {head.addr[31:2], 2'b00};
      if (head.opc[3]) begin
        case (head.opc[1:0])
          2'b00: begin
            dmem_wmask = 4'b0001 << head.addr[1:0];
            dmem_wdata = {24'b0, head.wdata[7:0]} << {head.addr[1:0], 3'b000};
          end
          2'b01: begin
            dmem_wmask = head.addr[1] ? 4'b1100 : 4'b0011;
            dmem_wdata = head.addr[1] ? {head.wdata[15:0], 16'b0} : {16'b0, head.wdata[15:0]};
          end
          default: begin
            dmem_wmask = 4'b1111;
            dmem_wdata = head.wdata;
          end
        endcase
      end else begin
        dmem_rmask = 4'b1111;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:  if (deq) state_next = head_mis ? RESP : MEM;
      // A flushed access still owes us a response unless it arrives right now.
      MEM:   if (flush)          state_next = dmem_resp ? IDLE : DRAIN;
             else if (dmem_resp) state_next = RESP;
      RESP:  if (flush || cdb_rdy) state_next = IDLE;
      DRAIN: if (dmem_resp)      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  lsu_load_align u_align (
    .rdata  (dmem_rdata),
    .off    (off_reg),
    .opc    (opc_reg),
    .result (load_result)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      opc_reg         <= '0;
      off_reg         <= '0;
      cdb_tag_reg     <= '0;
      cdb_inst_id_reg <= '0;
      cdb_wdata_reg   <= '0;
      cdb_exc_reg     <= 1'b0;
    end else if (deq) begin
      opc_reg         <= head.opc;
      off_reg         <= head.addr[1:0];
      cdb_tag_reg     <= TAG_W'(head.tag);
      cdb_inst_id_reg <= ROB_PTR_W'(head.inst_id);
      cdb_wdata_reg   <= '0;
      cdb_exc_reg     <= head_mis;
    end else if (state_reg == MEM && dmem_resp && !flush) begin
      cdb_wdata_reg   <= load_result;
    end
  end

  assign cdb_req     = (state_reg == RESP);
  assign cdb_tag     = cdb_tag_reg;
  assign cdb_inst_id = cdb_inst_id_reg;
  assign cdb_wdata   = cdb_wdata_reg;
  assign cdb_exc     = cdb_exc_reg;

endmodule

// File: tb/tb_lsu_lsq_v2.sv
// Directed and randomized checks of lsu_lsq_v2 against an in-order queue reference model.
module tb_lsu_lsq_v2;
  import rv32i_types::*;

  localparam int TAG_W = 4;
  localparam int ROB_PTR_W = 4;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst, flush, iss_req, iss_rdy, rob_head_vld, cdb_req, cdb_rdy, cdb_exc, dmem_resp;
  logic [3:0] iss_opc, dmem_rmask, dmem_wmask;
  logic [TAG_W-1:0] iss_tag, cdb_tag;
  logic [31:0] iss_src1, iss_src2, cdb_wdata, dmem_addr, dmem_wdata, dmem_rdata;
  logic [11:0] iss_offset;
  logic [ROB_PTR_W-1:0] iss_inst_id, rob_head_id, cdb_inst_id;

  always #5 clk = ~clk;

  lsu_lsq_v2 #(.TAG_W(TAG_W), .ROB_DEPTH(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .iss_req(iss_req), .iss_rdy(iss_rdy),
    .iss_opc(iss_opc), .iss_tag(iss_tag), .iss_src1(iss_src1), .iss_src2(iss_src2),
    .iss_offset(iss_offset), .iss_inst_id(iss_inst_id), .rob_head_vld(rob_head_vld),
    .rob_head_id(rob_head_id), .cdb_req(cdb_req), .cdb_rdy(cdb_rdy), .cdb_tag(cdb_tag),
    .cdb_inst_id(cdb_inst_id), .cdb_wdata(cdb_wdata), .cdb_exc(cdb_exc),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
  );

  typedef struct {
    logic [3:0]  opc;
    logic [3:0]  tag;
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] data;
  } op_t;

  op_t q[$];
  int checks = 0;
  int failures = 0;
  int wait_cycles;
  logic [3:0] op_tab [8];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int op_size(input logic [3:0] opc);
    if (opc == lsu_op_lb || opc == lsu_op_lbu || opc == lsu_op_sb) return 1;
    if (opc == lsu_op_lh || opc == lsu_op_lhu || opc == lsu_op_sh) return 2;
    return 4;
  endfunction

  function automatic bit is_store(input logic [3:0] opc);
    return opc == lsu_op_sb || opc == lsu_op_sh || opc == lsu_op_sw;
  endfunction

  function automatic logic [31:0] exp_load(input op_t e, input logic [31:0] rd);
    longint unsigned v, lim;
    int lane;
    lane = int'(e.addr % 4);
    lim = 64'd1 << (8 * op_size(e.opc));
    v = (64'(rd) >> (8 * lane)) % lim;
    if (is_store(e.opc)) return 32'd0;
    if ((e.opc == lsu_op_lb || e.opc == lsu_op_lh) && v >= lim / 2) v = v + (64'd1 << 32) - lim;
    return v[31:0];
  endfunction

  task automatic enq(input logic [3:0] opc, input logic [3:0] tag, input logic [3:0] id,
                     input logic [31:0] src1, input logic [31:0] data, input logic [11:0] off);
    op_t e;
    int o;
    iss_req = 1'b1; iss_opc = opc; iss_tag = tag; iss_inst_id = id;
    iss_src1 = src1; iss_src2 = data; iss_offset = off;
    #1;
    chk("iss_rdy_enq", 32'(iss_rdy), 32'(q.size() < DEPTH));
    tick();
    iss_req = 1'b0;
    o = $signed(off);
    e.opc = opc; e.tag = tag; e.id = id; e.addr = src1 + o; e.data = data;
    q.push_back(e);
  endtask

  task automatic wait_event();
    int found = 0;
    wait_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      if ((dmem_rmask | dmem_wmask) != 4'd0 || cdb_req) begin
        found = 1;
        break;
      end
      tick();
      wait_cycles++;
    end
    chk("wait_bound", 32'(found), 32'd1);
  endtask

  task automatic complete_one(input int lat, input logic [31:0] rd, input int rdy_delay);
    op_t e;
    int sz, lane;
    bit mis;
    logic [31:0] exp_w;
    e = q[0];
    sz = op_size(e.opc);
    lane = int'(e.addr % 4);
    mis = (e.addr % sz) != 0;
    rob_head_vld = 1'b1; rob_head_id = e.id; cdb_rdy = (rdy_delay == 0);
    #1;
    wait_event();
    if (mis) begin
      chk("mis_no_dmem", 32'({dmem_rmask, dmem_wmask}), 32'd0);
      exp_w = 32'd0;
      void'(q.pop_front());
    end else begin
      chk("dmem_addr", dmem_addr, e.addr & ~32'd3);
      if (is_store(e.opc)) begin
        chk("st_rmask", 32'(dmem_rmask), 32'd0);
        chk("st_wmask", 32'(dmem_wmask), ((32'd1 << sz) - 1) << lane);
        chk("st_wdata", dmem_wdata, 32'((64'(e.data) % (64'd1 << (8 * sz))) << (8 * lane)));
      end else begin
        chk("ld_rmask", 32'(dmem_rmask), 32'hF);
        chk("ld_wmask", 32'(dmem_wmask), 32'd0);
      end
      chk("iss_rdy_deq", 32'(iss_rdy), 32'(q.size() < DEPTH));
      void'(q.pop_front());
      tick();
      chk("req_one_cycle", 32'({dmem_rmask, dmem_wmask}), 32'd0);
      chk("iss_rdy_after", 32'(iss_rdy), 32'd1);
      for (int k = 0; k < lat; k++) begin
        chk("no_early_cdb", 32'(cdb_req), 32'd0);
        tick();
      end
      dmem_resp = 1'b1; dmem_rdata = rd;
      tick();
      dmem_resp = 1'b0; dmem_rdata = $urandom;
      exp_w = exp_load(e, rd);
    end
    chk("cdb_req", 32'(cdb_req), 32'd1);
    chk("cdb_exc", 32'(cdb_exc), 32'(mis));
    chk("cdb_wdata", cdb_wdata, exp_w);
    chk("cdb_tag", 32'(cdb_tag), 32'(e.tag));
    chk("cdb_inst_id", 32'(cdb_inst_id), 32'(e.id));
    for (int k = 0; k < rdy_delay; k++) begin
      tick();
      chk("cdb_hold", 32'(cdb_req), 32'd1);
      chk("cdb_stable", cdb_wdata, exp_w);
    end
    cdb_rdy = 1'b1;
    #1;
    tick();
    chk("cdb_drop", 32'(cdb_req), 32'd0);
  endtask

  task automatic rand_op(input logic [3:0] id, input bit force_store);
    logic [3:0] opc;
    logic [11:0] off;
    opc = op_tab[$urandom_range(0, 7)];
    if (force_store) opc = op_tab[$urandom_range(5, 7)];
    off = 12'($urandom_range(0, 15)) - 12'd8;
    enq(opc, 4'($urandom_range(0, 15)), id, 32'h1000 + 32'($urandom_range(0, 63)), $urandom, off);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] id_ctr;
    op_tab = '{lsu_op_lb, lsu_op_lh, lsu_op_lw, lsu_op_lbu, lsu_op_lhu, lsu_op_sb, lsu_op_sh, lsu_op_sw};
    rst = 1'b1; flush = 1'b0; iss_req = 1'b0; iss_opc = '0; iss_tag = '0; iss_src1 = '0;
    iss_src2 = '0; iss_offset = '0; iss_inst_id = '0; rob_head_vld = 1'b0; rob_head_id = '0;
    cdb_rdy = 1'b1; dmem_rdata = '0; dmem_resp = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    chk("rst_cdb_req", 32'(cdb_req), 32'd0);
    chk("rst_cdb_tag", 32'(cdb_tag), 32'd0);
    chk("rst_cdb_id", 32'(cdb_inst_id), 32'd0);
    chk("rst_cdb_wdata", cdb_wdata, 32'd0);
    chk("rst_cdb_exc", 32'(cdb_exc), 32'd0);
    chk("rst_iss_rdy", 32'(iss_rdy), 32'd1);
    chk("rst_masks", 32'({dmem_rmask, dmem_wmask}), 32'd0);

    // lw, 3-cycle memory latency
    enq(lsu_op_lw, 4'd3, 4'd1, 32'h100, 32'd0, 12'h000);
    complete_one(3, 32'hDEADBEEF, 0);
    // sign/zero extended byte loads
    enq(lsu_op_lb, 4'd4, 4'd2, 32'h100, 32'd0, 12'h003);
    complete_one(1, 32'h80123456, 0);
    enq(lsu_op_lbu, 4'd7, 4'd3, 32'h100, 32'd0, 12'h003);
    complete_one(0, 32'h80123456, 2);
    // store held until it is the ROB head
    rob_head_vld = 1'b1; rob_head_id = 4'd4;
    enq(lsu_op_sh, 4'd5, 4'd5, 32'h100, 32'h1234, 12'h002);
    for (int k = 0; k < 3; k++) begin
      chk("sh_blocked", 32'(dmem_wmask), 32'd0);
      tick();
    end
    complete_one(2, 32'd0, 0);
    // misaligned word load: exception one cycle after dequeue
    enq(lsu_op_lw, 4'd6, 4'd6, 32'h100, 32'd0, 12'h001);
    complete_one(0, 32'd0, 0);
    chk("mis_latency", 32'(wait_cycles), 32'd1);
    // negative offset
    enq(lsu_op_lw, 4'd8, 4'd7, 32'h200, 32'd0, 12'hFFC);
    complete_one(1, 32'hCAFEF00D, 1);

    // 20 random ops in batches, each led by a blocked store so the queue fills
    id_ctr = 4'd8;
    for (int b = 0; b < 3; b++) begin
      int n;
      n = (b < 2) ? DEPTH : 4;
      rob_head_vld = 1'b0;
      for (int j = 0; j < n; j++) begin
        rand_op(id_ctr, j == 0);
        id_ctr++;
      end
      #1;
      if (n == DEPTH) chk("full_iss_rdy", 32'(iss_rdy), 32'd0);
      for (int j = 0; j < n; j++) complete_one($urandom_range(0, 3), $urandom, $urandom_range(0, 1));
    end

    // flush in MEM: drain, second entry discarded, no access until drain completes
    rob_head_vld = 1'b0;
    enq(lsu_op_lw, 4'd1, 4'd1, 32'h300, 32'd0, 12'h000);
    enq(lsu_op_lw, 4'd2, 4'd2, 32'h304, 32'd0, 12'h000);
    chk("mem_no_issue", 32'({dmem_rmask, dmem_wmask}), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    q.delete();
    chk("drain_cdb", 32'(cdb_req), 32'd0);
    chk("drain_iss_rdy", 32'(iss_rdy), 32'd1);
    enq(lsu_op_lw, 4'd9, 4'd3, 32'h308, 32'd0, 12'h000);
    for (int k = 0; k < 2; k++) begin
      chk("drain_no_issue", 32'(dmem_rmask), 32'd0);
      tick();
    end
    dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    chk("drain_no_cdb", 32'(cdb_req), 32'd0);
    complete_one(1, 32'h13579BDF, 0);

    // flush in RESP while the CDB stalls
    enq(lsu_op_lw, 4'd4, 4'd4, 32'h400, 32'd0, 12'h000);
    wait_event();
    q.delete();
    tick();
    cdb_rdy = 1'b0; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    chk("resp_cdb", 32'(cdb_req), 32'd1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("resp_flush_drop", 32'(cdb_req), 32'd0);
    tick();
    chk("resp_flush_idle", 32'(cdb_req), 32'd0);
    cdb_rdy = 1'b1;

    // flush in MEM coinciding with the response
    enq(lsu_op_lw, 4'd5, 4'd5, 32'h500, 32'd0, 12'h000);
    wait_event();
    q.delete();
    tick();
    flush = 1'b1; dmem_resp = 1'b1;
    tick();
    flush = 1'b0; dmem_resp = 1'b0;
    chk("memresp_flush_cdb", 32'(cdb_req), 32'd0);
    chk("memresp_flush_idle", 32'(dmem_rmask), 32'd0);

    // reset mid-access; stale response ignored
    enq(lsu_op_lw, 4'd6, 4'd6, 32'h600, 32'd0, 12'h000);
    wait_event();
    q.delete();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; dmem_resp = 1'b1;
    tick();
    dmem_resp = 1'b0;
    chk("stale_resp_cdb", 32'(cdb_req), 32'd0);
    tick();
    chk("stale_resp_cdb2", 32'(cdb_req), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
